// File: rtl/comparator_pkg.sv
// Shared types and helpers for the serial magnitude comparator: FSM state
// encodings, the running relation between A and B, and small pure functions
// used by both the top level and the relation cell.
package comparator_pkg;

  // FSM states of the comparator top level.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Running relation of A versus B over the bits seen so far.
  typedef enum logic [1:0] {
    REL_EQ = 2'd0,
    REL_GT = 2'd1,
    REL_LT = 2'd2
  } rel_t;

  // Flag triple before any comparison has completed.
  localparam logic [2:0] FLAGS_NONE = 3'b000;

  // Counter width: enough to hold WIDTH-1, never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

  // One MSB-first step of the relation. The first differing bit pair decides
  // the relation; once decided it is frozen for the remaining bits.
  function automatic rel_t rel_step(input rel_t rel, input logic a, input logic b);
    if ((rel == REL_EQ) && (a != b)) begin
      return a ? REL_GT : REL_LT;
    end
    return rel;
  endfunction

  // Map a relation onto the one-hot {AGB, AEB, ALB} triple.
  function automatic logic [2:0] rel_to_flags(input rel_t rel);
    case (rel)
      REL_GT:  return 3'b100;
      REL_LT:  return 3'b001;
      default: return 3'b010;
    endcase
  endfunction

endpackage

// File: rtl/serial_compare_cell.sv
// Relation register of the serial comparator. Holds EQ/GT/LT for the bit
// pairs consumed so far; clear restarts at EQ, enable consumes one pair.
module serial_compare_cell
  import comparator_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic       a_bit,
  input  logic       b_bit,
  output logic [1:0] relation
);

  rel_t relation_reg;
  rel_t relation_next;

  // Next relation: clear wins, otherwise fold in the current bit pair.
  always_comb begin
    relation_next = relation_reg;
    if (clear) begin
      relation_next = REL_EQ;
    end else if (enable) begin
      relation_next = rel_step(relation_reg, a_bit, b_bit);
    end
  end

  // Relation register, reset to EQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      relation_reg <= REL_EQ;
    end else begin
      relation_reg <= relation_next;
    end
  end

  assign relation = relation_reg;

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial magnitude comparator. Operands A and B arrive MSB first, one
// bit pair per valid cycle; after WIDTH valid pairs the registered
// AGB/AEB/ALB flags are updated and done pulses for one cycle.
module serial_magnitude_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic AGB,
  output logic AEB,
  output logic ALB
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic [2:0]       flags_reg;
  logic [2:0]       flags_next;
  logic             busy_reg;
  logic             done_reg;

  logic             cell_clear;
  logic             cell_enable;
  logic [1:0]       relation;

  // A new comparison is accepted from IDLE or back-to-back from DONE.
  assign cell_clear  = start && (state_reg != ST_COMPARE);
  assign cell_enable = bit_valid && busy_reg;

  serial_compare_cell u_cell (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (cell_clear),
    .enable   (cell_enable),
    .a_bit    (a_bit),
    .b_bit    (b_bit),
    .relation (relation)
  );

  // Next-state, counter and flag update logic.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    flags_next = flags_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_COMPARE;
          count_next = CNT_LOAD;
        end
      end
      ST_COMPARE: begin
        // abort outranks the final valid bit: no result is published.
        if (abort) begin
          state_next = ST_IDLE;
        end else if (bit_valid) begin
          if (count_reg == '0) begin
            state_next = ST_DONE;
            // Include the final bit pair, which the cell absorbs on this edge.
            flags_next = rel_to_flags(rel_step(rel_t'(relation), a_bit, b_bit));
          end else begin
            count_next = count_reg - 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (start) begin
          state_next = ST_COMPARE;
          count_next = CNT_LOAD;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, counter and registered outputs; busy/done are decoded from the
  // next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
      flags_reg <= FLAGS_NONE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      flags_reg <= flags_next;
      busy_reg  <= (state_next == ST_COMPARE);
      done_reg  <= (state_next == ST_DONE);
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign AGB  = flags_reg[2];
  assign AEB  = flags_reg[1];
  assign ALB  = flags_reg[0];

endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
Bit-serial counterpart of the team's 4-bit parallel magnitude comparator. It receives operands A and B as a synchronous MSB-first bit stream and decides A>B, A==B or A<B. It reports the result with the same AGB/AEB/ALB flag triple plus a done strobe. It sits on narrow serial links where the parallel comparator's full-width operands are unavailable.

Parameters:
WIDTH, 4, operand width in bits; legal range 1..32.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous reset, active-low
start  input  1  begin a new comparison (single-cycle pulse)
abort  input  1  cancel the comparison in progress
bit_valid  input  1  a_bit/b_bit carry a valid operand bit this cycle
a_bit  input  1  current bit of A, MSB first
b_bit  input  1  current bit of B, MSB first
busy  output  1  comparison in progress (state COMPARE)
done  output  1  one-cycle strobe: result flags just updated
AGB  output  1  registered result, A greater than B
AEB  output  1  registered result, A equal to B
ALB  output  1  registered result, A less than B

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; busy=0, done=0, AGB=AEB=ALB=0; internal relation=EQ; bit counter=0.
- States: IDLE, COMPARE, DONE. All state and outputs are registered; no combinational input-to-output path.
- IDLE: start=1 -> COMPARE; bit counter loaded with WIDTH-1; internal relation set to EQ. bit_valid in IDLE is ignored.
- COMPARE: busy=1.
  - Each cycle with bit_valid=1 consumes one bit pair.
  - If relation==EQ and a_bit!=b_bit: relation becomes GT when a_bit=1, otherwise LT.
  - Once relation is GT or LT it is frozen; later bits are still consumed but ignored.
  - bit_valid=0 stalls: counter and relation hold; no timeout.
  - Valid bit with counter==0 -> DONE. Otherwise the counter decrements.
  - start during COMPARE is ignored.
- DONE (exactly one cycle): done=1, busy=0. AGB/AEB/ALB take the one-hot encoding of relation.
  - start=1 in this cycle -> COMPARE (back-to-back; counter/relation reloaded). Otherwise -> IDLE.
- Latency: done asserts on the clock edge after the WIDTH-th valid bit. With no stalls, start at cycle 0 and bits in cycles 1..WIDTH give done in cycle WIDTH+1.
- Result flags hold their value from the last DONE until the next DONE or reset. They are all zero only before the first DONE. After any DONE, exactly one flag is high.
- abort=1 in COMPARE -> IDLE next cycle. No done; flags unchanged. abort has priority over a simultaneous final valid bit. abort in IDLE/DONE is ignored.
- Simultaneous start and abort in IDLE: start wins. In COMPARE: abort wins.
- rst_n asserted mid-comparison: immediate return to reset values, including flags.
- Counter width is clog2(WIDTH) with a minimum of 1. For WIDTH=1, the first valid bit goes straight to DONE.

Decomposition:
- Shared package comparator_pkg holds:
  - state encodings ST_IDLE/ST_COMPARE/ST_DONE (2 bits);
  - relation encodings REL_EQ/REL_GT/REL_LT (2 bits);
  - a function mapping relation to the {AGB,AEB,ALB} one-hot triple.
- One natural sub-module: serial_compare_cell. It holds the relation register with clear, enable (bit_valid & busy), a_bit and b_bit inputs, and relation output. The top level owns the FSM, counter and output registers.

Test Plan:
- WIDTH=4. After reset: flags 000, busy=0, done=0. start, then bits of A=1100, B=0110 on 4 consecutive cycles -> done in cycle 5 with AGB=1, AEB=0, ALB=0.
- A=1110, B=1110 -> AEB=1. Then A=0011, B=0111 -> ALB=1 (decided at bit 2, flag held to end). Then A=1111, B=1110 -> AGB=1 (decided on the LSB).
- A=0010, B=0011 with bit_valid dropped for 3 cycles after bit 1 -> done exactly 1 cycle after the 4th valid bit; ALB=1; busy held through the stall.
- After a completed AGB result, start a new compare, then abort after 2 bits -> no done, state IDLE, AGB remains 1. Next: start with A=0110, B=0010 -> AGB=1.
- start asserted in the DONE cycle, then A=0010, B=0110 streamed immediately -> second done exactly 5 cycles after the first, ALB=1. start pulses during COMPARE cause no restart.
- rst_n low for 1 cycle mid-stream after 2 bits -> outputs 000, busy=0 immediately. A subsequent full compare (A=B=0000) -> AEB=1.
